// File: rtl/core_seq.sv
// Layer instruction sequencer for `core`: per kernel position it loads weights and
// activations, executes, drains psums to pmem, then accumulates the output pixels.
module core_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_kij  = 9,
    parameter int k_w      = 3,
    parameter int in_w     = 6,
    parameter int out_w    = 4,
    parameter int w_base   = 1024,
    parameter int act_base = 0,
    parameter int out_base = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);

    localparam int len_nij  = in_w * in_w;
    localparam int len_onij = out_w * out_w;
    localparam int AW = 11;
    localparam int CW = 6;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
    localparam logic [6:0]  CTL_NONE  = 7'b000_0000;
    localparam logic [6:0]  CTL_L0WR  = 7'b000_0100;
    localparam logic [6:0]  CTL_WLD   = 7'b000_1001;
    localparam logic [6:0]  CTL_EXE   = 7'b000_1010;
    localparam logic [6:0]  CTL_ORD   = 7'b100_0000;

    typedef enum logic [3:0] {
        S_IDLE, S_WRD, S_WLD, S_WGAP, S_ARD, S_EXE, S_DRN, S_ACC, S_AWR, S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    k_q;
    logic [4:0]    o_q;
    logic [33:0]   inst_q;
    logic          busy_q;
    logic          done_q;

    logic [CW-1:0] rd_last;
    logic          rd_active;
    logic [AW-1:0] x_addr;
    logic [AW-1:0] psum_base;
    logic [AW-1:0] acc_nij;

    // Enables are passed active-high here and inverted into the active-low memory pins.
    function automatic logic [33:0] mk_inst(input logic acc, input logic pmem_en,
                                            input logic pmem_wr, input logic [AW-1:0] a_pmem,
                                            input logic xmem_rd, input logic [AW-1:0] a_xmem,
                                            input logic [6:0] ctl);
        return {acc, ~pmem_en, ~pmem_wr, a_pmem, ~xmem_rd, 1'b1, a_xmem, ctl};
    endfunction

    always_comb begin
        rd_last   = (state_q == S_WRD) ? CW'(col) : CW'(len_nij);
        rd_active = (cnt_q < rd_last);
        x_addr    = (state_q == S_WRD) ? AW'(w_base) + AW'(k_q) * AW'(col) + AW'(cnt_q)
                                       : AW'(act_base) + AW'(cnt_q);
        psum_base = AW'(k_q) * AW'(len_nij);
        // Output pixel (o/out_w, o%out_w) reads input pixel shifted by kernel offset (k/k_w, k%k_w).
        acc_nij   = (AW'(o_q) / AW'(out_w) + AW'(k_q) / AW'(k_w)) * AW'(in_w)
                  + AW'(o_q) % AW'(out_w) + AW'(k_q) % AW'(k_w);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            o_q     <= '0;
            inst_q  <= INST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            inst_q <= INST_IDLE;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_WRD;
                        cnt_q   <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_WRD, S_ARD: begin
                    // L0 write trails the xmem read by one cycle, hence the extra cycle.
                    inst_q <= mk_inst(1'b0, 1'b0, 1'b0, '0, rd_active,
                                      rd_active ? x_addr : '0,
                                      (cnt_q != '0) ? CTL_L0WR : CTL_NONE);
                    if (cnt_q == rd_last) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == S_WRD) ? S_WLD : S_EXE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WLD: begin
                    inst_q <= mk_inst(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, CTL_WLD);
                    if (cnt_q == CW'(col - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_WGAP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WGAP: begin
                    if (cnt_q == CW'(row + col - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_ARD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_EXE: begin
                    inst_q <= mk_inst(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, CTL_EXE);
                    if (cnt_q == CW'(len_nij - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_DRN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRN: begin
                    if (ofifo_valid) begin
                        inst_q <= mk_inst(1'b0, 1'b1, 1'b1, psum_base + AW'(cnt_q),
                                          1'b0, '0, CTL_ORD);
                        if (cnt_q == CW'(len_nij - 1)) begin
                            cnt_q <= '0;
                            if (k_q == 4'(len_kij - 1)) begin
                                k_q     <= '0;
                                o_q     <= '0;
                                state_q <= S_ACC;
                            end else begin
                                k_q     <= k_q + 1'b1;
                                state_q <= S_WRD;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_ACC: begin
                    inst_q <= mk_inst(1'b1, 1'b1, 1'b0, psum_base + acc_nij, 1'b0, '0, CTL_NONE);
                    if (k_q == 4'(len_kij - 1)) begin
                        state_q <= S_AWR;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_AWR: begin
                    inst_q <= mk_inst(1'b0, 1'b1, 1'b1, AW'(out_base) + AW'(o_q), 1'b0, '0, CTL_NONE);
                    k_q    <= '0;
                    if (o_q == 5'(len_onij - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        o_q     <= o_q + 1'b1;
                        state_q <= S_ACC;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = k_q;

endmodule
